// File: rtl/ser_tx.sv
// ---------------------------------------------------------------------------
// ser_tx - parallel-to-serial transmitter
//
// Accepts a WIDTH-bit word over a PVALID/PREADY handshake and shifts it out
// one bit per CLK on SDATA, qualified by SVALID, with SLAST marking the final
// bit of each word. A new word may be accepted on the edge that retires the
// last bit of the current one, so words stream back-to-back with no gap.
//
// Parameters
//   WIDTH     word width in bits (2..32)
//   LSB_FIRST 1: bit 0 first, 0: bit WIDTH-1 first
//   INIT      SDATA level while idle and during reset
//
// Ports
//   CLK     in   clock, rising edge
//   RESETN  in   asynchronous active-low reset
//   PDATA   in   parallel word to transmit
//   PVALID  in   PDATA valid
//   PREADY  out  word can be accepted this cycle
//   SDATA   out  serial data bit
//   SVALID  out  SDATA carries a word bit
//   SLAST   out  current bit is the last bit of the word
// ---------------------------------------------------------------------------
module ser_tx #(
  parameter int   WIDTH     = 4,
  parameter bit   LSB_FIRST = 1'b1,
  parameter logic INIT      = 1'b0
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [WIDTH-1:0] PDATA,
  input  logic             PVALID,
  output logic             PREADY,
  output logic             SDATA,
  output logic             SVALID,
  output logic             SLAST
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic             rdy_en;
  logic             last_bit;
  logic             accept;

  // rdy_en holds PREADY low through reset and the first edge after release,
  // so a word presented while reset deasserts is never taken on that edge.
  assign last_bit = (state == SHIFT) && (cnt == LAST_CNT);
  assign PREADY   = rdy_en && ((state == IDLE) || last_bit);
  assign accept   = PVALID && PREADY;

  // Outputs depend only on registered state; PDATA/PVALID never reach them.
  assign SVALID = (state == SHIFT);
  assign SLAST  = last_bit;
  assign SDATA  = SVALID ? (LSB_FIRST ? shreg[0] : shreg[WIDTH-1]) : INIT;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  // NOTE: the shift register is cleared on reset too, so no stale word bits
  // survive a reset that lands mid-word.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state  <= IDLE;
      cnt    <= '0;
      shreg  <= '0;
      rdy_en <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      shreg  <= shreg_nxt;
      rdy_en <= 1'b1;
    end
  end

  // NOTE: every signal driven here gets a default first; a path that left one
  // unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shreg_nxt = shreg;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
          shreg_nxt = PDATA;
        end
      end
      SHIFT: begin
        if (cnt == LAST_CNT) begin
          cnt_nxt = '0;
          if (accept) begin
            shreg_nxt = PDATA;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
          shreg_nxt = LSB_FIRST ? (shreg >> 1) : (shreg << 1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ser_tx.sv
// ---------------------------------------------------------------------------
// tb_ser_tx - self-checking bench for ser_tx
//
// Two instances share stimulus: dut_a sends LSB first with INIT=0, dut_b sends
// MSB first with INIT=1. The reference model is a pair of bit queues: an
// accepted word is expanded into its serial bit order, the head of the queue
// is the bit expected on SDATA, and one bit retires per clock.
// ---------------------------------------------------------------------------
module tb_ser_tx;

  localparam int W      = 4;
  localparam bit INIT_A = 1'b0;
  localparam bit INIT_B = 1'b1;

  logic         CLK    = 1'b0;
  logic         RESETN = 1'b0;
  logic         PVALID = 1'b0;
  logic [W-1:0] PDATA  = '0;

  logic pready_a, sdata_a, svalid_a, slast_a;
  logic pready_b, sdata_b, svalid_b, slast_b;

  always #5 CLK = ~CLK;

  ser_tx #(.WIDTH(W), .LSB_FIRST(1'b1), .INIT(INIT_A)) dut_a (
    .CLK    (CLK),
    .RESETN (RESETN),
    .PDATA  (PDATA),
    .PVALID (PVALID),
    .PREADY (pready_a),
    .SDATA  (sdata_a),
    .SVALID (svalid_a),
    .SLAST  (slast_a)
  );

  ser_tx #(.WIDTH(W), .LSB_FIRST(1'b0), .INIT(INIT_B)) dut_b (
    .CLK    (CLK),
    .RESETN (RESETN),
    .PDATA  (PDATA),
    .PVALID (PVALID),
    .PREADY (pready_b),
    .SDATA  (sdata_b),
    .SVALID (svalid_b),
    .SLAST  (slast_b)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   qa[$];
  bit   qb[$];
  bit   started  = 1'b0;
  logic [7:0] seq_a, seq_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // A word can be taken when out of reset for at least one edge and at most
  // the final bit of the current word is still pending.
  function automatic bit exp_ready();
    return started && (qa.size() <= 1);
  endfunction

  function automatic void push_word(input logic [W-1:0] d);
    for (int i = 0; i < W; i++)      qa.push_back(d[i]);
    for (int i = W - 1; i >= 0; i--) qb.push_back(d[i]);
  endfunction

  function automatic void model_reset();
    qa.delete();
    qb.delete();
    started = 1'b0;
  endfunction

  task automatic check_outputs();
    check("a_pready", pready_a, exp_ready());
    check("a_svalid", svalid_a, qa.size() > 0);
    check("a_sdata",  sdata_a,  (qa.size() > 0) ? qa[0] : INIT_A);
    check("a_slast",  slast_a,  qa.size() == 1);
    check("b_pready", pready_b, exp_ready());
    check("b_svalid", svalid_b, qb.size() > 0);
    check("b_sdata",  sdata_b,  (qb.size() > 0) ? qb[0] : INIT_B);
    check("b_slast",  slast_b,  qb.size() == 1);
  endtask

  // Entered at a falling edge: drive inputs, check outputs, let one rising
  // edge pass, advance the model, and return at the next falling edge.
  task automatic cycle(input logic v, input logic [W-1:0] d);
    bit acc;
    PVALID = v;
    PDATA  = d;
    #1;
    check_outputs();
    if (svalid_a) seq_a = {seq_a[6:0], sdata_a};
    if (svalid_b) seq_b = {seq_b[6:0], sdata_b};
    acc = v && exp_ready();
    @(posedge CLK);
    if (!RESETN) begin
      model_reset();
    end else begin
      if (qa.size() > 0) qa.delete(0);
      if (qb.size() > 0) qb.delete(0);
      if (acc) push_word(d);
      started = 1'b1;
    end
    @(negedge CLK);
  endtask

  initial begin
    // Reset held with a word offered: everything must stay quiet.
    RESETN = 1'b0;
    @(negedge CLK);
    cycle(1'b1, W'($urandom));
    cycle(1'b1, W'($urandom));
    RESETN = 1'b1;
    // First edge after release: PREADY still 0, the offered word is refused.
    cycle(1'b1, W'($urandom));
    cycle(1'b0, '0);

    // Single word 1011.
    seq_a = '0; seq_b = '0;
    cycle(1'b1, 4'b1011);
    repeat (5) cycle(1'b0, '0);
    check("single_lsb_seq", {28'd0, seq_a[3:0]}, 32'b1101);
    check("single_msb_seq", {28'd0, seq_b[3:0]}, 32'b1011);

    // Back-to-back A then 5 with PVALID held through the word boundary.
    seq_a = '0; seq_b = '0;
    cycle(1'b1, 4'hA);
    repeat (4) cycle(1'b1, 4'h5);
    repeat (5) cycle(1'b0, '0);
    check("b2b_lsb_seq", {24'd0, seq_a}, 32'b0101_1010);
    check("b2b_msb_seq", {24'd0, seq_b}, 32'b1010_0101);

    // Backpressure: PDATA churns while a word is in flight.
    seq_a = '0; seq_b = '0;
    cycle(1'b1, 4'h3);
    cycle(1'b1, 4'h9);
    cycle(1'b1, 4'hE);
    cycle(1'b1, 4'h6);
    cycle(1'b1, 4'hC);
    cycle(1'b0, 4'h1);
    cycle(1'b0, 4'h7);
    cycle(1'b0, 4'h2);
    cycle(1'b0, 4'h8);
    cycle(1'b0, '0);
    check("bp_lsb_seq", {24'd0, seq_a}, 32'b1100_0011);

    // Reset asserted while bit 2 of 4'hF is on the wire.
    cycle(1'b1, 4'hF);
    cycle(1'b0, '0);
    cycle(1'b0, '0);
    #1 RESETN = 1'b0;
    #1;
    model_reset();
    check("midrst_svalid_a", svalid_a, 1'b0);
    check_outputs();
    @(negedge CLK);
    RESETN = 1'b1;
    repeat (3) cycle(1'b0, '0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, W'($urandom));
    end
    repeat (6) cycle(1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
